// File: rtl/conv_pkg.sv
// Shared types and size helpers for the serial convolution-layer sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Address width for a range of n entries; a 1-entry range still needs one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int out_dim(input int in_size, input int f_size, input int stride);
        return (in_size - f_size) / stride + 1;
    endfunction

    function automatic int num_taps(input int f_size);
        return f_size * f_size;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Kernel/position counters with incremental input, weight and bias address generation.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int NUM_FILTERS = 16,
    parameter int INPUT_SIZE  = 28,
    parameter int FILTER_SIZE = 7,
    parameter int STRIDE      = 2,
    localparam int O  = out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE),
    localparam int T  = num_taps(FILTER_SIZE),
    localparam int IW = clog2_min1(INPUT_SIZE * INPUT_SIZE),
    localparam int WW = clog2_min1(NUM_FILTERS * T),
    localparam int FW = clog2_min1(NUM_FILTERS),
    localparam int PW = clog2_min1(O * O)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance_tap,
    input  logic          advance_pos,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] w_addr,
    output logic [FW-1:0] bias_addr,
    output logic [PW-1:0] pos_idx,
    output logic          tap_first,
    output logic          tap_last,
    output logic          pos_last
);

    localparam int KW = clog2_min1(FILTER_SIZE);
    localparam int OW = clog2_min1(O);
    localparam int TW = clog2_min1(T);

    localparam logic [KW-1:0] K_LAST   = KW'(FILTER_SIZE - 1);
    localparam logic [OW-1:0] O_LAST   = OW'(O - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(NUM_FILTERS - 1);
    localparam logic [IW-1:0] IN_STEP  = IW'(INPUT_SIZE);
    localparam logic [IW-1:0] ROW_STEP = IW'(STRIDE * INPUT_SIZE);
    localparam logic [IW-1:0] COL_STEP = IW'(STRIDE);
    localparam logic [WW-1:0] T_STEP   = WW'(T);

    logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
    logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [FW-1:0] f_q, f_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [IW-1:0] row_off_q, row_off_d, row_base_q, row_base_d, col_base_q, col_base_d;
    logic [WW-1:0] f_base_q, f_base_d;

    // Tap counters are never wrapped by advance_tap, so addresses hold after the last tap.
    always_comb begin
        kc_d       = kc_q;
        kr_d       = kr_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        f_d        = f_q;
        pos_d      = pos_q;
        tap_d      = tap_q;
        row_off_d  = row_off_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        f_base_d   = f_base_q;
        if (advance_pos) begin
            kc_d      = '0;
            kr_d      = '0;
            tap_d     = '0;
            row_off_d = '0;
            if (ox_q == O_LAST) begin
                ox_d       = '0;
                col_base_d = '0;
                if (oy_q == O_LAST) begin
                    oy_d       = '0;
                    row_base_d = '0;
                    pos_d      = '0;
                    f_d        = f_q + FW'(1);
                    f_base_d   = f_base_q + T_STEP;
                end else begin
                    oy_d       = oy_q + OW'(1);
                    row_base_d = row_base_q + ROW_STEP;
                    pos_d      = pos_q + PW'(1);
                end
            end else begin
                ox_d       = ox_q + OW'(1);
                col_base_d = col_base_q + COL_STEP;
                pos_d      = pos_q + PW'(1);
            end
        end else if (advance_tap) begin
            tap_d = tap_q + TW'(1);
            if (kc_q == K_LAST) begin
                kc_d      = '0;
                kr_d      = kr_q + KW'(1);
                row_off_d = row_off_q + IN_STEP;
            end else begin
                kc_d = kc_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            kc_q       <= '0;
            kr_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            f_q        <= '0;
            pos_q      <= '0;
            tap_q      <= '0;
            row_off_q  <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            f_base_q   <= '0;
        end else begin
            kc_q       <= kc_d;
            kr_q       <= kr_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            f_q        <= f_d;
            pos_q      <= pos_d;
            tap_q      <= tap_d;
            row_off_q  <= row_off_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            f_base_q   <= f_base_d;
        end
    end

    assign in_addr   = row_base_q + col_base_q + row_off_q + IW'(kc_q);
    assign w_addr    = f_base_q + WW'(tap_q);
    assign bias_addr = f_q;
    assign pos_idx   = pos_q;
    assign tap_first = (kr_q == '0) && (kc_q == '0);
    assign tap_last  = (kr_q == K_LAST) && (kc_q == K_LAST);
    assign pos_last  = (f_q == F_LAST) && (oy_q == O_LAST) && (ox_q == O_LAST);

endmodule

// File: rtl/conv_layer_ctrl.sv
// Serial convolution-layer sequencer: one shared MAC walks filter, row, column and tap.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int NUM_FILTERS = 16,
    parameter int INPUT_SIZE  = 28,
    parameter int FILTER_SIZE = 7,
    parameter int STRIDE      = 2,
    localparam int O  = out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE),
    localparam int T  = num_taps(FILTER_SIZE),
    localparam int IW = clog2_min1(INPUT_SIZE * INPUT_SIZE),
    localparam int WW = clog2_min1(NUM_FILTERS * T),
    localparam int FW = clog2_min1(NUM_FILTERS),
    localparam int PW = clog2_min1(O * O)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] w_addr,
    output logic [FW-1:0] bias_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [FW-1:0] out_filter,
    output logic [PW-1:0] out_pos,
    output state_e        state_dbg
);

    state_e state_q;
    logic   busy_q, done_q, mac_en_q, mac_clr_q, mac_last_q, out_valid_q;
    logic   tap_first, tap_last, pos_last;
    logic   clear, advance_tap, advance_pos;

    assign clear       = (state_q == S_IDLE) && start;
    assign advance_tap = (state_q == S_RUN) && !tap_last;
    assign advance_pos = (state_q == S_EMIT) && out_ready && !pos_last;

    conv_addr_gen #(
        .NUM_FILTERS (NUM_FILTERS),
        .INPUT_SIZE  (INPUT_SIZE),
        .FILTER_SIZE (FILTER_SIZE),
        .STRIDE      (STRIDE)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .advance_tap (advance_tap),
        .advance_pos (advance_pos),
        .in_addr     (in_addr),
        .w_addr      (w_addr),
        .bias_addr   (bias_addr),
        .pos_idx     (out_pos),
        .tap_first   (tap_first),
        .tap_last    (tap_last),
        .pos_last    (pos_last)
    );

    // Output handshake: out_valid stays high with out_filter/out_pos frozen until a
    // cycle where out_ready is also high; that cycle is the transfer, and out_valid
    // drops on the following edge. out_ready is ignored while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // Strobes trail the address issue cycle by one to line up with read data.
            mac_en_q   <= (state_q == S_RUN);
            mac_clr_q  <= (state_q == S_RUN) && tap_first;
            mac_last_q <= (state_q == S_RUN) && tap_last;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (tap_last) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    state_q     <= S_EMIT;
                    out_valid_q <= 1'b1;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pos_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign mac_last   = mac_last_q;
    assign out_valid  = out_valid_q;
    assign out_filter = bias_addr;
    assign state_dbg  = state_q;

endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Sequencer that time-multiplexes one external multiply-accumulate engine across every filter and output position of a convolution layer. Walks filter, output row, output column and kernel tap in that order. Generates input, weight and bias memory read addresses, aligns the MAC control strobes with 1-cycle read data, and hands each finished output to downstream storage over a valid/ready handshake. This is the serial, area-reduced replacement for instantiating one convolution filter per output channel.

## Interface
- NUM_FILTERS, 16, output channels
- INPUT_SIZE, 28, input feature map edge length (square)
- FILTER_SIZE, 7, kernel edge length (square)
- STRIDE, 2, window step in both dimensions
- Derived: O = (INPUT_SIZE-FILTER_SIZE)/STRIDE+1; T = FILTER_SIZE²; widths are clog2 of each address range, minimum 1

Ports:
- clk  in  1  clock; one clock domain; synchronous, active-high reset
- reset  in  1  synchronous, active-high
- start  in  1  begin a layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final output handshake
- in_addr  out  clog2(INPUT_SIZE²)  input read address, row-major
- w_addr  out  clog2(NUM_FILTERS·T)  weight read address = f·T + kr·FILTER_SIZE + kc
- bias_addr  out  clog2(NUM_FILTERS)  = f
- mac_en  out  1  read data valid this cycle; MAC must accumulate
- mac_clr  out  1  with mac_en: MAC loads bias + in·w instead of accumulating
- mac_last  out  1  with mac_en: final tap of the current output
- out_valid  out  1  MAC accumulator holds a finished output
- out_ready  in  1  downstream accepts it
- out_filter  out  clog2(NUM_FILTERS)  filter index of the presented output
- out_pos  out  clog2(O²)  oy·O + ox of the presented output

## Operation
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE → RUN on start. All counters (f, oy, ox, kr, kc) are cleared.
- RUN issues one tap per cycle at in_addr = (oy·STRIDE+kr)·INPUT_SIZE + ox·STRIDE + kc.
  - kc is the innermost counter, then kr.
  - After tap T-1 the state goes to DRAIN.
- Addresses come from incremental row/column base registers; no run-time multipliers.
- mac_en, mac_clr and mac_last are the issue-cycle flags (tap valid, tap 0, tap T-1) registered once.
- DRAIN lasts exactly one cycle. It carries the registered last-tap strobes. Then the state goes to EMIT.
- EMIT holds out_valid=1 until out_ready.
  - out_filter and out_pos stay stable while stalled.
  - On the handshake, advance ox, then oy, then f, and go to RUN.
  - If the handshake is for the last output (f=NUM_FILTERS-1, oy=ox=O-1), go to DONE instead.
- DONE asserts done for one cycle, then returns to IDLE.
- start while busy is ignored. start in the DONE cycle is ignored.
- Reset in any state:
  - state goes to IDLE and all counters clear;
  - every output goes to 0;
  - in-flight MAC strobes and any pending output are discarded.

## Timing
- Reset values: busy=done=mac_en=mac_clr=mac_last=out_valid=0; all addresses, out_filter and out_pos = 0.
- Read latency is 1 cycle: data for the address issued in cycle t is valid in t+1, and mac_en is high in t+1.
- Per output, cycles are: T (RUN) + 1 (DRAIN) + ≥1 (EMIT). With out_ready tied high this is T+2 cycles.
- out_valid rises the cycle after the mac_last cycle.
- start accepted at edge k: first tap is issued in cycle k+1.
- done is high in the cycle after the final handshake.
- Addresses in DRAIN, EMIT, DONE and IDLE hold their last value. They are don't-care to consumers.

## Structure
- Shared package conv_pkg holds:
  - the state enum;
  - width and derived-size functions: O, T, address widths.
- One sub-module, conv_addr_gen, holds the kernel/position counters and the incremental address arithmetic.
  - Inputs: clear, advance_tap, advance_pos.
  - Outputs: in_addr, w_addr, bias_addr, tap_first, tap_last, pos_last.

## Test plan
All scenarios use NUM_FILTERS=2, INPUT_SIZE=5, FILTER_SIZE=3, STRIDE=2, so O=2 and T=9.
- Single start, out_ready=1:
  - 8 outputs, 11 cycles apart;
  - (out_filter, out_pos) sequence is (0,0),(0,1),(0,2),(0,3),(1,0)…(1,3);
  - done 1 cycle after the 8th handshake.
- Address check at f=0, oy=0, ox=1:
  - in_addr sequence is 2,3,4,7,8,9,12,13,14;
  - w_addr is 0..8;
  - at f=1, w_addr is 9..17 and bias_addr=1.
- Strobe alignment:
  - mac_clr only with the first mac_en;
  - mac_last only with the 9th;
  - exactly 9 mac_en cycles per output.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT. out_valid, out_filter and out_pos stay stable, there are no mac_en pulses, and the next RUN starts the cycle after the handshake.
- Reset asserted mid-RUN of output 3:
  - next cycle: IDLE with all outputs 0;
  - a new start restarts at (0,0) with in_addr=0.
- start pulsed while busy and in DONE: ignored, with exactly 8 outputs and one done. A start in the following IDLE cycle launches a fresh layer.
